// File: rtl/rx_mod.sv
// rx_mod -- 8N1 UART receiver with 16x oversampling, mid-bit start
// qualification, stop-bit check and a single-byte holding register.
//
// Parameters:
//   OS_DIV      clk cycles per oversample tick (bit period = 16*OS_DIV clk)
//   SYNC_STAGES flops in the rxd synchronizer (2..3)
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   rxd        asynchronous serial input, idles high
//   rd         one-cycle consume strobe; clears rx_rdy and the error flags
//   dout       received byte, dout[0] = first data bit on the line
//   rx_rdy     dout holds an unread byte
//   frame_err  stop bit of the byte in dout was sampled 0
//   overrun    a byte completed while rx_rdy=1 and was discarded
//   rx_busy    receiver is not idle
//   parity_err (RX_PARITY_EN only) even-parity check failed for dout
//
// Build option: define RX_PARITY_EN to expect an even-parity bit between
// D7 and the stop bit (11-bit frames).

module rx_mod #(
   parameter int OS_DIV      = 27,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       rd,
   output logic [7:0] dout,
   output logic       rx_rdy,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_busy
`ifdef RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int PW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(OS_DIV - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
   localparam logic [2:0] BRK    = 3'd4;
`ifdef RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd5;
`endif

   logic [SYNC_STAGES-1:0] sync;
   logic                   rs;
   logic [2:0]             state;
   logic [PW-1:0]          presc;
   logic                   tick;
   logic [3:0]             tcnt;
   logic [3:0]             bcnt;
   logic [7:0]             shreg;
   logic                   commit;
   logic                   stop_s;
`ifdef RX_PARITY_EN
   logic                   par_bad;
`endif

   assign rs      = sync[SYNC_STAGES-1];
   assign tick    = (state != IDLE) && (presc == PRESC_LAST);
   assign rx_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync      <= '1;
         state     <= IDLE;
         presc     <= '0;
         tcnt      <= '0;
         bcnt      <= '0;
         shreg     <= '0;
         commit    <= 1'b0;
         stop_s    <= 1'b0;
         dout      <= '0;
         rx_rdy    <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], rxd};
         commit <= 1'b0;

         // Held at 0 while idle, so the first tick after a start edge
         // arrives exactly OS_DIV cycles after detection.
         if (state == IDLE || state == BRK || presc == PRESC_LAST)
            presc <= '0;
         else
            presc <= presc + 1'b1;

         case (state)
            IDLE: begin
               tcnt <= '0;
               if (!rs)
                  state <= START;
            end
            START: begin
               if (tick) begin
                  if (tcnt == 4'd7) begin
                     tcnt <= '0;
                     if (rs) begin
                        state <= IDLE;
                     end else begin
                        state <= DATA;
                        bcnt  <= '0;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  tcnt <= tcnt + 1'b1;
                  if (tcnt == 4'd15) begin
                     shreg <= {rs, shreg[7:1]};
                     bcnt  <= bcnt + 1'b1;
                     if (bcnt == 4'd7)
`ifdef RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                  end
               end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  tcnt <= tcnt + 1'b1;
                  if (tcnt == 4'd15) begin
                     par_bad <= rs ^ (^shreg);
                     state   <= STOP;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  tcnt <= tcnt + 1'b1;
                  if (tcnt == 4'd15) begin
                     stop_s <= rs;
                     commit <= 1'b1;
                     // Re-arm at mid-stop; a low stop parks in BRK until the
                     // line returns high so the break is not read as a start.
                     state  <= rs ? IDLE : BRK;
                  end
               end
            end
            BRK: begin
               if (rs)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (commit) begin
            if (!rx_rdy || rd) begin
               dout      <= shreg;
               rx_rdy    <= 1'b1;
               frame_err <= ~stop_s;
`ifdef RX_PARITY_EN
               parity_err <= par_bad;
`endif
               if (rd)
                  overrun <= 1'b0;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rd) begin
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_rx_mod.sv
// tb_rx_mod -- self-checking bench for rx_mod (OS_DIV=4, 64 clk per bit).
// Table-driven frames plus hand-written sequences for break, overrun,
// read-at-commit and mid-frame reset; a queue holds the expected bytes.

module tb_rx_mod;

   localparam int OS  = 4;
   localparam int BIT = 16 * OS;
`ifdef RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   // Start-edge drive to rx_rdy: 2 sync flops + 1 detect cycle, mid-stop
   // sample 8+16*(NB-1) ticks later, then 1 commit cycle.
   localparam int LAT_NOM = 3 + (8 + 16 * (NB - 1)) * OS + 1;

   logic       clk = 1'b0;
   logic       rst, rxd, rd;
   logic [7:0] dout;
   logic       rx_rdy, frame_err, overrun, rx_busy;
`ifdef RX_PARITY_EN
   logic       parity_err;
   logic       force_bad_par = 1'b0;
`endif

   rx_mod #(.OS_DIV(OS), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .rd        (rd),
      .dout      (dout),
      .rx_rdy    (rx_rdy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .rx_busy   (rx_busy)
`ifdef RX_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       ov;
      logic       pe;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] edout;
      logic       efe;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[4];
   int   checks = 0;
   int   passed = 0;
   int   lat;
   logic prev_rdy = 1'b0;
   exp_t e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int tail);
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         repeat (BIT) @(negedge clk);
      end
`ifdef RX_PARITY_EN
      rxd = (^d) ^ force_bad_par;
      repeat (BIT) @(negedge clk);
`endif
      rxd = stop_bit;
      repeat (BIT + tail) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic pulse_rd();
      @(negedge clk) rd = 1'b1;
      @(negedge clk) rd = 1'b0;
   endtask

   // Scoreboard monitor: every rising rx_rdy consumes one expected record.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_rdy && !prev_rdy) begin
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL sb_unexpected: rx_rdy rose with dout=0x%0h, expected no byte", dout);
            end else begin
               e = sb.pop_front();
               chk("sb_dout", dout, e.d);
               chk("sb_frame_err", frame_err, e.fe);
               chk("sb_overrun", overrun, e.ov);
`ifdef RX_PARITY_EN
               chk("sb_parity_err", parity_err, e.pe);
`endif
            end
         end
         prev_rdy = rx_rdy;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
      tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
      tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
      tbl[3] = '{8'h96, 1'b0, 8'h96, 1'b1};

      rst = 1'b1; rxd = 1'b1; rd = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_dout", dout, 8'h00);
      chk("rst_rx_rdy", rx_rdy, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_rx_busy", rx_busy, 1'b0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         sb.push_back('{tbl[i].edout, tbl[i].efe, 1'b0, 1'b0});
         fork
            send_frame(tbl[i].data, tbl[i].stop, 0);
            begin
               lat = 0;
               while (!rx_rdy && lat < LAT_NOM + 200) begin
                  @(negedge clk);
                  lat++;
               end
            end
         join
         checks++;
         if (lat >= LAT_NOM - 8 && lat <= LAT_NOM + 8) passed++;
         else $display("FAIL latency: got %0d clk, expected %0d +/- 8", lat, LAT_NOM);
         repeat (4) @(negedge clk);
         chk("tbl_rx_rdy_set", rx_rdy, 1'b1);
         pulse_rd();
         chk("tbl_rd_clears_rdy", rx_rdy, 1'b0);
         chk("tbl_rd_clears_fe", frame_err, 1'b0);
         repeat (10) @(negedge clk);
      end

      // Short low glitch is rejected at the mid-start check.
      rxd = 1'b0;
      repeat (10) @(negedge clk);
      chk("glitch_busy", rx_busy, 1'b1);
      repeat (10) @(negedge clk);
      rxd = 1'b1;
      repeat (100) @(negedge clk);
      chk("glitch_idle", rx_busy, 1'b0);
      chk("glitch_rdy", rx_rdy, 1'b0);
      chk("glitch_fe", frame_err, 1'b0);
      chk("glitch_ov", overrun, 1'b0);

      // Framing error with the line held low (break), then a clean frame.
      sb.push_back('{8'h3C, 1'b1, 1'b0, 1'b0});
      send_frame(8'h3C, 1'b0, 200 - BIT);
      repeat (150) @(negedge clk);
      chk("brk_dout", dout, 8'h3C);
      chk("brk_fe", frame_err, 1'b1);
      chk("brk_no_restart", overrun, 1'b0);
      chk("brk_rdy", rx_rdy, 1'b1);
      chk("brk_idle", rx_busy, 1'b0);
      pulse_rd();
      sb.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
      send_frame(8'h81, 1'b1, 0);
      repeat (4) @(negedge clk);
      pulse_rd();
      chk("after_brk_rd", rx_rdy, 1'b0);

      // Back-to-back frames without rd: second byte is discarded.
      sb.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b1, 0);
      repeat (10) @(negedge clk);
      chk("ovr_dout", dout, 8'h11);
      chk("ovr_flag", overrun, 1'b1);
      chk("ovr_rdy", rx_rdy, 1'b1);
      chk("ovr_fe", frame_err, 1'b0);
      pulse_rd();
      chk("ovr_rd_rdy", rx_rdy, 1'b0);
      chk("ovr_rd_ov", overrun, 1'b0);
      chk("ovr_rd_fe", frame_err, 1'b0);

      // rd in the exact commit cycle of the second byte.
      sb.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
      send_frame(8'h11, 1'b1, 0);
      fork
         send_frame(8'h22, 1'b1, 0);
         begin
            repeat (LAT_NOM - 1) @(posedge clk);
            @(negedge clk) rd = 1'b1;
            @(negedge clk) rd = 1'b0;
         end
      join
      chk("rdc_dout", dout, 8'h22);
      chk("rdc_rdy", rx_rdy, 1'b1);
      chk("rdc_ov", overrun, 1'b0);
      pulse_rd();

      // Reset during D3; remaining bits are all high so no start follows.
      fork
         send_frame(8'hFD, 1'b1, 0);
         begin
            repeat (4 * BIT + 20) @(negedge clk);
            rst = 1'b1;
            @(negedge clk) rst = 1'b0;
         end
      join
      repeat (100) @(negedge clk);
      chk("mrst_rdy", rx_rdy, 1'b0);
      chk("mrst_dout", dout, 8'h00);
      chk("mrst_fe", frame_err, 1'b0);
      chk("mrst_ov", overrun, 1'b0);
      chk("mrst_busy", rx_busy, 1'b0);

      sb.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
      send_frame(8'h5A, 1'b1, 0);
      repeat (4) @(negedge clk);
      pulse_rd();
      chk("post_rst_rd", rx_rdy, 1'b0);

`ifdef RX_PARITY_EN
      force_bad_par = 1'b1;
      sb.push_back('{8'h5A, 1'b0, 1'b0, 1'b1});
      send_frame(8'h5A, 1'b1, 0);
      force_bad_par = 1'b0;
      repeat (4) @(negedge clk);
      pulse_rd();
      chk("par_rd_clears", parity_err, 1'b0);
`endif

      repeat (10) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/rx_mod.md
Name: rx_mod

Overview:
- UART receiver: deserialises an asynchronous 8N1 serial line (`rxd`) into bytes, LSB first.
- Pairs with the team's UART transmitter on the far end of the link.
- Generates its own 16x oversampling tick from `clk`, qualifies the start bit with a mid-bit check, and checks the stop bit.
- Holds each received byte in a single holding register until the consumer pulses `rd`.
- Flags framing and overrun errors.

Parameters:
- `OS_DIV`, default 27: clk cycles per oversample tick. Bit period = 16*`OS_DIV` clk. The default gives 50 MHz / 115200 baud.
- `SYNC_STAGES`, default 2: number of flip-flops in the `rxd` synchronizer. Legal range 2..3.

Ports:
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  synchronous reset, active-high.
- `rxd`  input  1  asynchronous serial line; idles high.
- `rd`  input  1  one-cycle consume strobe. Clears `rx_rdy`, `frame_err`, `overrun`.
- `dout`  output  8  received byte (holding register), `dout[0]` = first data bit on the line.
- `rx_rdy`  output  1  1 = `dout` holds an unread byte.
- `frame_err`  output  1  stop bit of the byte in `dout` was sampled 0.
- `overrun`  output  1  a byte completed while `rx_rdy`=1; that byte was discarded.
- `rx_busy`  output  1  1 while state != IDLE.

Behaviour:
- Reset (`rst`=1 at posedge `clk`):
  - state=IDLE; prescaler, tick counter and bit counter = 0.
  - Synchronizer flops = 1, shift register = 0.
  - `dout`=0x00, `rx_rdy`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0.
  - Reset mid-frame abandons the frame with no output update.
- Synchronizer: `rxd` passes through `SYNC_STAGES` flops. All decisions use the synchronized value `rs`.
- Prescaler: counts 0..`OS_DIV`-1 and emits tick when it equals `OS_DIV`-1.
  - Restarted at 0 in the cycle a start edge is detected.
  - Held at 0 in IDLE.
- Tick counter: 4-bit, counts ticks within a bit. A sample is taken when it reaches 7 (mid-bit, START) or 15 (one full bit later, DATA/STOP), then it wraps to 0.
- States:
  - IDLE: `rs`=0 -> START.
  - START: at tick 7, `rs`=0 -> DATA with bit counter=0; `rs`=1 -> IDLE (glitch rejected, no flags).
  - DATA: every 16 ticks, shift `rs` in from the MSB end (shift right), bit counter+1. After the 8th sample -> STOP.
  - STOP: 16 ticks after the last data sample, sample `rs` and commit (see Commit). Then `rs`=1 -> IDLE, `rs`=0 -> BREAK.
  - BREAK: wait for `rs`=1, then IDLE. No start detection while in BREAK.
- Commit (1 clk after the stop sample):
  - If `rx_rdy`=0, or `rd`=1 in the same cycle:
    - `dout` <= shift register.
    - `rx_rdy` <= 1.
    - `frame_err` <= ~stop_sample.
    - `overrun` <= 0 if `rd`=1 in the same cycle, otherwise unchanged.
  - Else: `dout` and `frame_err` unchanged, `overrun` <= 1.
- `rd` with no commit in the same cycle: `rx_rdy`, `frame_err`, `overrun` <= 0 next cycle. `rd` while `rx_rdy`=0 is harmless.
- Re-arm: IDLE is re-entered at mid-stop, so a start edge arriving half a bit later is caught. Back-to-back frames are received without loss.
- Latency: `rx_rdy` rises 1 clk after the mid-stop sample, i.e. about 9.5 bit periods after the start edge.

Optional Feature:
- `RX_PARITY_EN` defined:
  - An even-parity bit is expected between D7 and stop. State PARITY sits between DATA and STOP and is sampled 16 ticks after D7.
  - Extra output `parity_err` (1 bit, reset 0) is committed together with `frame_err` under the same rules and cleared by `rd`.
  - Frame length is 11 bits.
- Undefined: no PARITY state, no `parity_err` port, 10-bit frames.

Test Plan (`OS_DIV`=4, bit period = 64 clk):
- Idle line, then frame 0xA5 with stop=1 -> `rx_rdy`=1 about 608 clk after the start edge; `dout`=0xA5, `frame_err`=0, `overrun`=0. `rd` pulse -> `rx_rdy`=0.
- Low glitch of 20 clk on an idle line -> state returns to IDLE; `rx_rdy` and all flags stay 0.
- Frame 0x3C with stop bit driven 0, line held low for 200 clk, then released -> `dout`=0x3C, `frame_err`=1. No new start is detected until the line is high; a following 0x81 frame is then received correctly.
- Frames 0x11 then 0x22 back-to-back, no `rd` -> `dout`=0x11, `overrun`=1. `rd` -> all flags 0.
- `rd` asserted in the exact commit cycle of 0x22 while 0x11 is unread -> `dout`=0x22, `rx_rdy`=1, `overrun`=0.
- `rst` asserted for 1 clk during D3 of a frame, followed by the frame remainder -> no `rx_rdy` and all outputs at reset values. The next clean 0x5A frame is received correctly. With `RX_PARITY_EN`, 0x5A with parity bit 1 -> `parity_err`=1.
